cart_rom_ctrl: RTL and testbench

Sequencer and arbiter for the cartridge SDRAM channel 0, sitting between hps_io download, the supervision CPU bus and the sdram controller.
- Serialises ROM download writes using the ioctl_wait back-pressure.
- Derives the power-of-two ROM address mask and the large_rom flag from the download size.
- Serves CPU reads through a one-entry read cache, so repeated fetches of the same byte skip SDRAM.

---
 rtl/cart_pkg.sv | 29 ++
 rtl/cart_rd_cache.sv | 41 ++++
 rtl/cart_rom_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cart_rom_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartridge ROM channel: FSM state
// encoding, default address widths and the power-of-two mask smear.
package cart_pkg;

  localparam int CART_ADDR_W    = 19;
  localparam int CART_DL_ADDR_W = 25;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_WAIT,
    RD,
    RD_WAIT
  } state_t;

  // Every bit below the highest set bit becomes 1, giving the next
  // power of two minus one that covers the address.
  function automatic logic [31:0] mask_smear(input logic [31:0] addr);
    logic [31:0] m;
    m = addr;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/cart_rd_cache.sv
// Single-entry read cache for CPU ROM fetches: one tag/data/valid
// register with combinational lookup, fill and invalidate.
module cart_rd_cache
  import cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_tag,
  output logic              hit,
  output logic [7:0]        hit_data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [7:0]        fill_data,
  input  logic              invalidate
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [7:0]        data;

  // Invalidate wins over fill so a fresh download never keeps stale bytes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

endmodule

// File: rtl/cart_rom_ctrl.sv
// Sequencer/arbiter for cartridge SDRAM channel 0: serialises ROM download
// writes, derives the ROM mask and serves CPU reads through a one-entry cache.
module cart_rom_ctrl
  import cart_pkg::*;
#(
  parameter int          ADDR_W     = CART_ADDR_W,
  parameter int          DL_ADDR_W  = CART_DL_ADDR_W,
  parameter logic [7:0]  BLANK_DATA = 8'hFF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [DL_ADDR_W-1:0] dl_addr,
  input  logic [7:0]           dl_data,
  output logic                 dl_wait,
  input  logic                 cpu_rd,
  input  logic [ADDR_W-1:0]    cpu_addr,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_valid,
  output logic [DL_ADDR_W-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [7:0]           mem_din,
  input  logic [7:0]           mem_dout,
  input  logic                 mem_busy,
  output logic [ADDR_W-1:0]    rom_mask,
  output logic                 large_rom
);

  state_t            state, state_n;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] rd_tag;
  logic              dl_active_q;
  logic              dl_fresh;
  logic              first_wr;
  logic              rd_req;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_tag;
  logic              accept_wr;
  logic              serve_rd;
  logic              start_rd;
  logic              respond;
  logic [7:0]        resp_data;
  logic              cache_hit;
  logic [7:0]        cache_data;
  logic              rd_done;

  // A fresh CPU request takes the slot over any older pending one.
  assign rd_req    = cpu_rd | pend_valid;
  assign req_addr  = cpu_rd ? cpu_addr : pend_addr;
  assign req_tag   = req_addr & rom_mask;
  assign first_wr  = dl_fresh | (dl_active & ~dl_active_q);
  assign rd_done   = (state == RD_WAIT) && !mem_busy;
  assign mem_wr    = (state == WR);
  assign mem_rd    = (state == RD);
  assign large_rom = |rom_mask[ADDR_W-1:ADDR_W-2];

  cart_rd_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .lookup_tag (req_tag),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill       (rd_done),
    .fill_tag   (rd_tag),
    .fill_data  (mem_dout),
    .invalidate (accept_wr & first_wr)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept_wr = 1'b0;
    serve_rd  = 1'b0;
    start_rd  = 1'b0;
    respond   = 1'b0;
    resp_data = BLANK_DATA;
    case (state)
      IDLE: begin
        if (dl_wr) begin
          accept_wr = 1'b1;
          state_n   = WR;
        end else if (rd_req) begin
          serve_rd = 1'b1;
          if (dl_active) begin
            respond = 1'b1;
          end else if (cache_hit) begin
            respond   = 1'b1;
            resp_data = cache_data;
          end else begin
            start_rd = 1'b1;
            state_n  = RD;
          end
        end
      end
      WR:      state_n = WR_WAIT;
      WR_WAIT: if (!mem_busy) state_n = IDLE;
      RD:      state_n = RD_WAIT;
      RD_WAIT: begin
        if (!mem_busy) begin
          respond   = 1'b1;
          resp_data = mem_dout;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Back-pressure drops in the completion cycle so the next byte lands in IDLE.
  always_comb begin
    dl_wait = 1'b0;
    if (dl_active) begin
      case (state)
        IDLE:             dl_wait = dl_wr;
        WR, RD:           dl_wait = 1'b1;
        WR_WAIT, RD_WAIT: dl_wait = mem_busy;
        default:          dl_wait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_din  <= '0;
      rom_mask <= '1;
      rd_tag   <= '0;
    end else if (accept_wr) begin
      mem_addr <= dl_addr;
      mem_din  <= dl_data;
      rom_mask <= ADDR_W'(mask_smear(32'(dl_addr[ADDR_W-1:0])));
    end else if (start_rd) begin
      mem_addr <= DL_ADDR_W'(req_tag);
      rd_tag   <= req_tag;
    end
  end

  // Reads that cannot start now (busy or losing to a write) park here.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else if (cpu_rd && ((state != IDLE) || dl_wr)) begin
      pend_valid <= 1'b1;
      pend_addr  <= cpu_addr;
    end else if (serve_rd) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      dl_fresh    <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      dl_fresh    <= accept_wr ? 1'b0 : first_wr;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_valid <= 1'b0;
      cpu_dout  <= BLANK_DATA;
    end else begin
      cpu_valid <= respond;
      if (respond) cpu_dout <= resp_data;
    end
  end

endmodule

// File: tb/tb_cart_rom_ctrl.sv
// Scoreboard bench for cart_rom_ctrl with a busy-stretching SDRAM model.
module tb_cart_rom_ctrl;

  typedef struct {
    logic        is_wr;
    logic [24:0] addr;
    logic [7:0]  data;
  } mem_op_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr, dl_wait;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_rd, cpu_valid;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [24:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_busy;
  logic [18:0] rom_mask;
  logic        large_rom;

  int checks = 0;
  int errors = 0;
  int busy_len;
  int busy_cnt;
  int lat;
  logic        wait_at_strobe;
  logic        strobe_wr, strobe_rd;
  logic [24:0] strobe_addr;
  logic [7:0]  strobe_din;
  logic [7:0]  rd_hold;
  logic [18:0] ref_mask;
  mem_op_t     mem_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  ref_mem[logic [24:0]];
  logic [7:0]  sdram[logic [24:0]];

  cart_rom_ctrl dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_valid (cpu_valid),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_busy  (mem_busy),
    .rom_mask  (rom_mask),
    .large_rom (large_rom)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [18:0] model_mask(input logic [18:0] a);
    logic [18:0] m = '0;
    for (int i = 0; i < 19; i++)
      if (a[i]) m = 19'((32'd1 << (i + 1)) - 1);
    return m;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [18:0] tag);
    logic [24:0] a = 25'(tag);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // SDRAM model: strobes seen mid-cycle, busy for busy_len cycles after.
  always @(negedge clk_sys) begin
    strobe_wr   = mem_wr;
    strobe_rd   = mem_rd;
    strobe_addr = mem_addr;
    strobe_din  = mem_din;
  end

  always @(posedge clk_sys) begin
    if (strobe_wr || strobe_rd) begin
      if (strobe_wr) sdram[strobe_addr] = strobe_din;
      rd_hold = sdram.exists(strobe_addr) ? sdram[strobe_addr] : 8'h00;
      mem_busy <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (mem_busy) begin
      if (busy_cnt == 0) begin
        mem_busy <= 1'b0;
        mem_dout <= rd_hold;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Scoreboard: every strobe and every cpu_valid must match a pushed expectation.
  always @(negedge clk_sys) begin
    mem_op_t op;
    logic [7:0] exp_byte;
    if (!reset && (mem_wr || mem_rd)) begin
      checkOutput("mem_strobe_expected", 32'(mem_q.size() != 0), 1);
      if (mem_q.size() != 0) begin
        op = mem_q.pop_front();
        checkOutput("mem_op_is_wr", 32'(mem_wr), 32'(op.is_wr));
        checkOutput("mem_addr", 32'(mem_addr), 32'(op.addr));
        if (op.is_wr) checkOutput("mem_din", 32'(mem_din), 32'(op.data));
      end
    end
    if (cpu_valid) begin
      checkOutput("rd_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) begin
        exp_byte = rd_q.pop_front();
        checkOutput("cpu_dout", 32'(cpu_dout), 32'(exp_byte));
      end
    end
  end

  // rd_kind: 0 blank, 1 cache hit, 2 miss, 3 miss aborted by reset
  task automatic applyStimulus(input bit do_wr, input logic [24:0] wa, input logic [7:0] wd,
                               input bit do_rd, input logic [18:0] ra, input int rd_kind);
    logic [18:0] tag;
    @(negedge clk_sys);
    if (do_wr) begin
      dl_wr   = 1'b1;
      dl_addr = wa;
      dl_data = wd;
      mem_q.push_back('{is_wr: 1'b1, addr: wa, data: wd});
      ref_mem[wa] = wd;
      ref_mask    = model_mask(wa[18:0]);
    end
    if (do_rd) begin
      cpu_rd   = 1'b1;
      cpu_addr = ra;
      tag      = ra & ref_mask;
      if (rd_kind >= 2) mem_q.push_back('{is_wr: 1'b0, addr: 25'(tag), data: 8'h00});
      if (rd_kind == 0) rd_q.push_back(8'hFF);
      else if (rd_kind != 3) rd_q.push_back(ref_rd(tag));
    end
    #1 wait_at_strobe = dl_wait;
    @(posedge clk_sys);
    #1;
    dl_wr  = 1'b0;
    cpu_rd = 1'b0;
  endtask

  task automatic downloadByte(input logic [24:0] a, input logic [7:0] d);
    int n;
    applyStimulus(1'b1, a, d, 1'b0, '0, 0);
    n = wait_at_strobe ? 1 : 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (!dl_wait) break;
      n++;
    end
    checkOutput("dl_wait_cycles", 32'(n), 32'(busy_len + 2));
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      cycles++;
      if (cpu_valid) break;
    end
  endtask

  task automatic cpuRead(input logic [18:0] a, input int rd_kind);
    applyStimulus(1'b0, '0, '0, 1'b1, a, rd_kind);
    waitValid(lat);
    checkOutput("rd_latency", 32'(lat), (rd_kind == 2) ? 32'(busy_len + 3) : 32'd1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_dl_wait", 32'(dl_wait), 0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    checkOutput("rst_mem_din", 32'(mem_din), 0);
    checkOutput("rst_cpu_valid", 32'(cpu_valid), 0);
    checkOutput("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    checkOutput("rst_rom_mask", 32'(rom_mask), 32'h7FFFF);
    checkOutput("rst_large_rom", 32'(large_rom), 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    cpu_rd    = 1'b0;
    cpu_addr  = '0;
    mem_dout  = 8'h00;
    mem_busy  = 1'b0;
    busy_cnt  = 0;
    busy_len  = 3;
    ref_mask  = '1;
    ref_mem[25'h31234] = 8'hA5;
    sdram[25'h31234]   = 8'hA5;

    repeat (3) @(posedge clk_sys);
    #1 checkResetState();
    reset = 1'b0;

    $display("[TB] four-byte download");
    dl_active = 1'b1;
    for (int i = 0; i < 4; i++) downloadByte(25'(i), 8'(8'h11 * (i + 1)));
    dl_active = 1'b0;
    checkOutput("mask_4byte", 32'(rom_mask), 32'(ref_mask));
    checkOutput("large_4byte", 32'(large_rom), 32'(|ref_mask[18:17]));

    $display("[TB] large rom, miss then hit");
    dl_active = 1'b1;
    downloadByte(25'h2FFFF, 8'h9E);
    dl_active = 1'b0;
    checkOutput("mask_large", 32'(rom_mask), 32'(ref_mask));
    checkOutput("large_large", 32'(large_rom), 32'(|ref_mask[18:17]));
    cpuRead(19'h71234, 2);
    cpuRead(19'h71234, 1);

    $display("[TB] new download invalidates cache");
    dl_active = 1'b1;
    downloadByte(25'h2FFFF, 8'h3C);
    dl_active = 1'b0;
    cpuRead(19'h71234, 2);

    $display("[TB] reads refused during download");
    dl_active = 1'b1;
    cpuRead(19'h71234, 0);
    cpuRead(19'h00005, 0);
    dl_active = 1'b0;

    $display("[TB] simultaneous write and read");
    @(negedge clk_sys);
    dl_active = 1'b1;
    applyStimulus(1'b1, 25'h2FFFF, 8'h5C, 1'b1, 19'h2FFFF, 2);
    dl_active = 1'b0;
    waitValid(lat);
    checkOutput("wr_then_rd_latency", 32'(lat), 32'(2 * busy_len + 6));

    $display("[TB] short busy, small rom aliasing");
    busy_len  = 1;
    dl_active = 1'b1;
    downloadByte(25'h00010, 8'h42);
    dl_active = 1'b0;
    checkOutput("mask_small", 32'(rom_mask), 32'(ref_mask));
    cpuRead(19'h40010, 2);
    cpuRead(19'h00030, 1);
    cpuRead(19'h00000, 2);

    $display("[TB] reset during read wait");
    busy_len = 6;
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00001, 3);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (mem_busy) break;
      lat++;
    end
    checkOutput("reached_rd_wait", 32'(mem_busy), 1);
    #1 reset = 1'b1;
    ref_mask = '1;
    #1 checkResetState();
    @(posedge clk_sys);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (!mem_busy) break;
    end
    cpuRead(19'h00000, 2);

    repeat (3) @(negedge clk_sys);
    checkOutput("rd_q_drained", 32'(rd_q.size()), 0);
    checkOutput("mem_q_drained", 32'(mem_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
